// File: rtl/arm_regfile_mp.sv
// Multi-port ARM register file: NUM_RD combinational reads, WB + link writes, PC shadow, pending-write scoreboard.
// Optional REGFILE_BYPASS_EN: same-cycle write data and last-clear forwarded to the read ports.
module arm_regfile_mp #(
  parameter int DATA_W    = 32,
  parameter int NUM_REGS  = 16,
  parameter int NUM_RD    = 3,
  parameter int PC_IDX    = 15,
  parameter int LR_IDX    = 14,
  parameter int PC_OFFSET = 8,
  parameter int SB_W      = 2,
  localparam int AW       = $clog2(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RD*AW-1:0]     rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr0_en,
  input  logic [AW-1:0]            wr0_addr,
  input  logic [DATA_W-1:0]        wr0_data,
  input  logic                     wr1_en,
  input  logic [DATA_W-1:0]        wr1_data,
  input  logic                     pc_we,
  input  logic [DATA_W-1:0]        pc_in,
  output logic [DATA_W-1:0]        pc_out,
  input  logic                     sb_set_en,
  input  logic [AW-1:0]            sb_set_addr,
  input  logic                     sb_clr_en,
  output logic [1:0]               err
);

  localparam logic [AW-1:0] PC_A = AW'(PC_IDX);
  localparam logic [AW-1:0] LR_A = AW'(LR_IDX);

  logic [DATA_W-1:0]              regs_q [NUM_REGS];
  logic [DATA_W-1:0]              pc_q;
  logic [NUM_REGS-1:0][SB_W-1:0]  sb_q;
  logic [NUM_REGS-1:0][SB_W-1:0]  sb_next;
  logic [NUM_REGS-1:0]            sb_inc;
  logic [NUM_REGS-1:0]            sb_dec;
  logic [NUM_REGS-1:0]            wr_hit0;
  logic [NUM_REGS-1:0]            wr_hit1;
  logic                           sb_err;
  logic [1:0]                     err_q;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      // wr0 never lands on the PC slot; the PC lives in its own shadow register
      assign wr_hit0[gi] = wr0_en && (wr0_addr == AW'(gi)) && (gi != PC_IDX);
      assign wr_hit1[gi] = wr1_en && (gi == LR_IDX);
      assign sb_inc[gi]  = sb_set_en && (sb_set_addr == AW'(gi)) && (gi != PC_IDX);
      assign sb_dec[gi]  = sb_clr_en && (wr0_addr == AW'(gi));
    end
  endgenerate

  // Saturating pending counters; simultaneous set and clear cancel out
  always_comb begin
    sb_err  = 1'b0;
    sb_next = sb_q;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (sb_inc[r] && !sb_dec[r]) begin
        if (&sb_q[r]) sb_err = 1'b1;
        else          sb_next[r] = sb_q[r] + SB_W'(1);
      end else if (sb_dec[r] && !sb_inc[r]) begin
        if (sb_q[r] == '0) sb_err = 1'b1;
        else               sb_next[r] = sb_q[r] - SB_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NUM_REGS; r++) regs_q[r] <= '0;
      sb_q  <= '0;
      pc_q  <= '0;
      err_q <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (wr_hit0[r])      regs_q[r] <= wr0_data;
        else if (wr_hit1[r]) regs_q[r] <= wr1_data;
      end
      sb_q <= sb_next;
      if (pc_we) pc_q <= pc_in;
      err_q <= err_q | {wr0_en && (wr0_addr == PC_A), sb_err};
    end
  end

  generate
    for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [AW-1:0]     addr;
      logic [DATA_W-1:0] data;
      logic              busy;
      assign addr = rd_addr[gi*AW +: AW];

      always_comb begin
        data = '0;
        busy = 1'b0;
        if (addr == PC_A) begin
          data = pc_q + DATA_W'(PC_OFFSET);
        end else if (int'(addr) < NUM_REGS) begin
`ifdef REGFILE_BYPASS_EN
          if (wr0_en && (wr0_addr == addr)) data = wr0_data;
          else if (wr1_en && (addr == LR_A)) data = wr1_data;
          else data = regs_q[addr];
`else
          data = regs_q[addr];
`endif
        end
        if (int'(addr) < NUM_REGS) begin
`ifdef REGFILE_BYPASS_EN
          busy = (sb_q[addr] != '0) &&
                 !(sb_dec[addr] && !sb_inc[addr] && (sb_q[addr] == SB_W'(1)));
`else
          busy = (sb_q[addr] != '0);
`endif
        end
      end

      assign rd_data[gi*DATA_W +: DATA_W] = data;
      assign rd_busy[gi] = busy;
    end
  endgenerate

  assign pc_out = pc_q;
  assign err    = err_q;

endmodule

// File: doc/arm_regfile_mp.md
Name: arm_regfile_mp

Overview:
- Parametrised multi-port register file for the ARM pipelined core: NUM_RD combinational read ports and two write ports (WB result, link/LR).
- PC shadow register; PC-index reads return pc + PC_OFFSET.
- Per-register pending-write scoreboard so the hazard unit can detect RAW hazards without comparing addresses across pipeline stages.
- Sits in Decode; writes come from Writeback, PC from Fetch.

Parameters:
- DATA_W, 32, register width in bits.
- NUM_REGS, 16, number of architectural registers; AW = $clog2(NUM_REGS).
- NUM_RD, 3, number of read ports.
- PC_IDX, 15, index returning the PC view.
- LR_IDX, 14, index written by port wr1.
- PC_OFFSET, 8, constant added to the PC on PC-index reads.
- SB_W, 2, width of each scoreboard pending counter.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- rd_addr  in  NUM_RD*AW  read addresses; port i = bits [i*AW +: AW].
- rd_data  out  NUM_RD*DATA_W  read data; port i = bits [i*DATA_W +: DATA_W].
- rd_busy  out  NUM_RD  port i address has pending write count > 0.
- wr0_en  in  1  writeback write enable.
- wr0_addr  in  AW  writeback address.
- wr0_data  in  DATA_W  writeback data.
- wr1_en  in  1  link write enable (BL); writes LR_IDX.
- wr1_data  in  DATA_W  link value.
- pc_we  in  1  PC shadow update enable.
- pc_in  in  DATA_W  new PC value.
- pc_out  out  DATA_W  current PC shadow.
- sb_set_en  in  1  instruction issued that will write sb_set_addr.
- sb_set_addr  in  AW  destination of the issued instruction.
- sb_clr_en  in  1  retire of a scoreboarded write; normally tied to wr0_en.
- err  out  2  sticky errors: [0] scoreboard overflow/underflow, [1] wr0 targeting PC_IDX.

Behaviour:
- Reset (reset=1 at posedge):
  - All registers, pc, every pending counter and err clear to 0.
  - After reset, rd_data reads 0 for normal indices and PC_OFFSET for PC_IDX; rd_busy reads 0; pc_out reads 0.
- Reads: combinational, zero latency.
  - rd_addr == PC_IDX returns pc + PC_OFFSET, modulo 2^DATA_W.
  - Any other address returns the register value, with bypass (see Optional Feature).
  - Addresses >= NUM_REGS (non-power-of-2 NUM_REGS) return 0.
- Writes: on posedge when not in reset.
  - wr0_en writes wr0_data to wr0_addr.
  - wr1_en writes wr1_data to LR_IDX.
  - If both target LR_IDX in the same cycle, wr0 wins.
  - wr0 to PC_IDX is discarded, the register is unchanged, and err[1] is set.
  - pc_we loads pc_in into pc.
- Scoreboard: one SB_W-bit counter per register.
  - sb_set_en increments the counter for sb_set_addr.
  - sb_clr_en decrements the counter for wr0_addr.
  - Set and clear on the same register in the same cycle leave the counter unchanged.
  - Increment at all-ones saturates and sets err[0].
  - Decrement at 0 holds 0 and sets err[0].
  - Counter changes are visible on rd_busy the cycle after the edge.
  - sb_set_addr == PC_IDX is ignored.
- err bits are sticky until reset.
- Reset mid-operation: reset has priority over all writes, pc_we and scoreboard updates in the same cycle.

Optional Feature:
- Macro REGFILE_BYPASS_EN.
- Defined: a read whose address matches a same-cycle write returns the incoming data (wr0_data, or wr1_data for LR_IDX, applying the wr0-wins rule). rd_busy for that port also reads 0 when sb_clr_en clears the last pending count in that cycle.
- Undefined: reads return the stored value only; new data is visible the next cycle. The hazard unit must then stall one extra cycle on WB→Decode dependencies.

Test Plan:
- Reset, then read ports 0..2 at r0, r15, r14 → 0x0, 0x8, 0x0; rd_busy=0; err=0.
- pc_we with pc_in=0x100, then read r15 → 0x108. Then wr0 to r15 with data 0xDEAD → r15 still reads 0x108 and err[1]=1.
- wr0 r3=0x1234 and wr1=0x5555 same cycle → next cycle r3=0x1234 and r14=0x5555. Then wr0 r14=0xAAAA with wr1=0x5555 → r14=0xAAAA.
- sb_set r5 three times → rd_busy for r5 =1. A fourth set → counter saturates at 3 and err[0]=1. Then set and clear r5 in the same cycle → count stays 3. Three clears → rd_busy=0.
- With REGFILE_BYPASS_EN defined, wr0 r7=0xCAFE while reading r7 → rd_data=0xCAFE the same cycle. With the macro undefined → old value the same cycle, 0xCAFE the next cycle.
- Assert reset while wr0_en=1 and sb_set_en=1 → the target register stays 0, its counter stays 0 and err stays 0.
